fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register.
- Sits directly upstream of the decode stage and its RAW hazard detector.
- Owns the PC, issues single-outstanding requests to instruction memory, and presents {valid, instr, pc} to decode.
- Honours the decoder's stall (hold IF/ID, buffer one returning instruction) and the execute stage's redirect (flush and restart).

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, encoding driven on id_instr when id_valid=0 (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
stallPipe  in  1  from hazard detection: hold IF/ID contents
redirect  in  1  taken branch/jump from execute: flush and refetch
redirect_pc  in  XLEN  new PC; bits [1:0] ignored (forced 0)
imem_req  out  1  request valid
imem_addr  out  XLEN  request word address (bits [1:0]=0)
imem_ready  in  1  memory accepts request this cycle (req & ready)
imem_rvalid  in  1  response valid, at least 1 cycle after acceptance
imem_rdata  in  32  response instruction
id_valid  out  1  IF/ID holds a real instruction
id_instr  out  32  IF/ID instruction
id_pc  out  XLEN  IF/ID instruction address

Behaviour:
- Reset (rst=1 at clk edge), applies in any state, mid-request included:
  - pc_q=RESET_PC; state=IDLE; kill=0; buf_valid=0.
  - id_valid=0; id_instr=NOP_INSTR; id_pc=0.
  - imem_req=0 while rst is high.
  - A response arriving after reset that belongs to a pre-reset request is undefined. The memory is reset together with this block.
- FSM:
  - IDLE: imem_req=1, imem_addr=pc_q when buf_valid=0 and redirect=0.
    - On req & imem_ready: pend_pc<=pc_q; pc_q<=pc_q+4 (wraps modulo 2^XLEN); go to WAIT.
  - WAIT: imem_req=0.
    - On imem_rvalid: go to IDLE.
    - If kill=1, discard the data and clear kill.
    - Otherwise deliver {imem_rdata, pend_pc}.
  - Throughput: at most one instruction per 2 cycles (the no-back-to-back issue limit is intentional).
- Delivery / IF/ID update. Priority per cycle, highest first:
  1. redirect:
     - id_valid<=0, id_instr<=NOP_INSTR; buf_valid<=0; pc_q<=redirect_pc & ~3.
     - In WAIT without rvalid: kill<=1.
     - In WAIT with rvalid the same cycle: drop the response and go to IDLE.
     - In IDLE: no request is issued that cycle.
     - Redirect overrides stallPipe.
  2. stallPipe=1:
     - IF/ID holds all three outputs.
     - A delivered instruction is written to the 1-entry buffer (buf_valid<=1).
     - Buffer full blocks new requests, so overflow cannot occur.
  3. buf_valid=1: IF/ID<=buffer; buf_valid<=0. A same-cycle delivery cannot exist (buffer full blocks issue).
  4. Delivery present: IF/ID<={1, rdata, pend_pc}.
  5. Otherwise: bubble, id_valid<=0, id_instr<=NOP_INSTR; id_pc holds its old value.
- Ordering: instructions reach IF/ID in strict PC order. No instruction is duplicated or lost across stall.
- Flushed instructions never reach IF/ID.
- kill is set only in WAIT and clears on the next imem_rvalid.
- A redirect while kill=1 re-targets pc_q only; kill stays 1.

Test Plan:
1. Reset then imem_ready=1, rvalid 1 cycle after accept, rdata=0x00100093 → first id_valid=1 with id_pc=0, id_instr=0x00100093; next request addr=0x4; no stall means one instruction every 2 cycles.
2. Hold stallPipe=1 for 5 cycles while the response for PC 0x8 (0x00208133) arrives → IF/ID holds the PC 0x4 instruction; imem_req stays 0 while buffered; after stall drops, IF/ID=0x00208133 / 0x8 on the next edge, then fetch of 0xC resumes.
3. redirect=1, redirect_pc=0x103 while WAIT (request for 0x10 outstanding) → id_valid=0 next cycle; the 0x10 response is discarded; next imem_addr=0x100; id_pc=0x100 delivered.
4. redirect and stallPipe high together, with buf_valid=1 → buffer cleared, id_valid=0, fetch restarts at redirect_pc.
5. redirect in the same cycle as imem_rvalid → response dropped; next cycle imem_req=1 with addr=redirect_pc.
6. pc_q=0xFFFF_FFFC fetched → next imem_addr=0x0000_0000; rst asserted mid-WAIT → all outputs at reset values next cycle, next request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: single-outstanding imem requests,
// one-entry skid buffer for decode stalls, and execute-stage redirect/flush.
module fetch_stage #(
    parameter int unsigned           XLEN      = 32,
    parameter logic [XLEN-1:0]       RESET_PC  = '0,
    parameter logic [31:0]           NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallPipe,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            kill_q, kill_d;
    logic            buf_valid_q, buf_valid_d;
    logic [31:0]     buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic            id_valid_q, id_valid_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;

    logic accept;
    logic deliver;

    // A full buffer or a redirect suppresses issue so the skid entry can never overflow.
    assign imem_req  = !rst && (state_q == S_IDLE) && !buf_valid_q && !redirect;
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;
    assign deliver   = (state_q == S_WAIT) && imem_rvalid && !kill_q;

    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        kill_d      = kill_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        id_valid_d  = id_valid_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pend_pc_d = pc_q;
                    pc_d      = pc_q + XLEN'(4);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                    kill_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            pc_d        = redirect_pc & ~XLEN'(3);
            id_valid_d  = 1'b0;
            id_instr_d  = NOP_INSTR;
            buf_valid_d = 1'b0;
            if ((state_q == S_WAIT) && !imem_rvalid) begin
                kill_d = 1'b1;
            end
        end else if (stallPipe) begin
            if (deliver) begin
                buf_valid_d = 1'b1;
                buf_instr_d = imem_rdata;
                buf_pc_d    = pend_pc_q;
            end
        end else if (buf_valid_q) begin
            id_valid_d  = 1'b1;
            id_instr_d  = buf_instr_q;
            id_pc_d     = buf_pc_q;
            buf_valid_d = 1'b0;
        end else if (deliver) begin
            id_valid_d  = 1'b1;
            id_instr_d  = imem_rdata;
            id_pc_d     = pend_pc_q;
        end else begin
            id_valid_d  = 1'b0;
            id_instr_d  = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            pend_pc_q   <= '0;
            kill_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= '0;
            id_valid_q  <= 1'b0;
            id_instr_q  <= NOP_INSTR;
            id_pc_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            kill_q      <= kill_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
        end
    end

endmodule
